// File: rtl/hsid_x_obi_inf_pkg.sv
// OBI request/response payloads shared by hsid_x masters and slave models.
//   obi_req_t  : req, we, be[3:0], addr[31:0], wdata[31:0]
//   obi_resp_t : gnt, rvalid, rdata[31:0]
package hsid_x_obi_inf_pkg;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

endpackage

// File: rtl/pixel_obi_mem_mo.sv
// pixel_obi_mem_mo: OBI slave memory model for pixel data with up to
// MAX_OUTSTANDING in-order reads, programmable grant-to-rvalid latency,
// pseudo-random grant stalls and selectable data modes.
// Optional write-back store: define PIXEL_OBI_MEM_WRITE_EN.
// Ports:
//   clk, rst_n  : clock, async active-low reset
//   obi_req     : OBI request (req, we, be, addr, wdata)
//   obi_rsp     : OBI response (gnt combinational; rvalid, rdata registered)
//   mode_i      : 0 ADDR_MASK, 1 LFSR, 2 ZERO, 3 ADDR
//   latency_i   : grant-to-rvalid cycles (0 treated as 1)
//   stall_en_i  : runtime enable of random grant stall
module pixel_obi_mem_mo
  import hsid_x_obi_inf_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 16,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned RANDOM_GNT      = 1,
  parameter logic [15:0] GNT_SEED        = 16'hACE1,
  parameter logic [31:0] VAL_SEED        = 32'h1234_5678,
  parameter logic [31:0] VALUE_MASK      = 32'h0000_3FFF,
  parameter int unsigned STORE_AW        = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  obi_req_t   obi_req,
  output obi_resp_t  obi_rsp,
  input  logic [1:0] mode_i,
  input  logic [3:0] latency_i,
  input  logic       stall_en_i
);

  localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [1:0] MODE_ADDR_MASK = 2'd0;
  localparam logic [1:0] MODE_LFSR      = 2'd1;
  localparam logic [1:0] MODE_ZERO      = 2'd2;

  logic [15:0]          stall_lfsr;
  logic [31:0]          data_lfsr;
  logic [7:0]           cnt;
  logic [31:0]          fifo_data [MAX_OUTSTANDING];
  logic [7:0]           fifo_due  [MAX_OUTSTANDING];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]     fifo_cnt;
  logic                 rvalid_q;
  logic [31:0]          rdata_q;

  logic                  gnt_c, full_c, push_c, pop_c, bypass_c, head_ready_c;
  logic [CNT_W-1:0]      occ_c;
  logic [3:0]            lat_eff_c;
  logic [7:0]            cnt_nxt_c, acc_due_c, head_age_c;
  logic [31:0]           acc_data_c;
  logic [DATA_WIDTH-1:0] mask_val_c;

`ifdef PIXEL_OBI_MEM_WRITE_EN
  localparam int unsigned STORE_DEPTH = 1 << STORE_AW;
  logic [31:0]            store_mem [STORE_DEPTH];
  logic [STORE_DEPTH-1:0] store_vld;
  logic [STORE_AW-1:0]    st_idx_c;
  logic [31:0]            st_new_c;

  // Byte-merge a write into the addressed word; never-written bytes read as 0.
  always_comb begin
    st_idx_c = obi_req.addr[STORE_AW+1:2];
    st_new_c = store_vld[st_idx_c] ? store_mem[st_idx_c] : '0;
    for (int b = 0; b < 4; b++) begin
      if (obi_req.be[b]) st_new_c[8*b +: 8] = obi_req.wdata[8*b +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      store_vld <= '0;
    end else if (gnt_c && obi_req.we) begin
      store_vld[st_idx_c] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (gnt_c && obi_req.we) store_mem[st_idx_c] <= st_new_c;
  end
`else
  logic unused_wr;
  assign unused_wr = ^{obi_req.be, obi_req.wdata};
`endif

  // Grant, accept data/due computation and response scheduling.
  always_comb begin
    // The beat currently on rvalid still owns its slot until the cycle ends.
    occ_c     = fifo_cnt + CNT_W'(rvalid_q);
    full_c    = (occ_c >= CNT_W'(MAX_OUTSTANDING));
    gnt_c     = obi_req.req && !full_c &&
                !((RANDOM_GNT != 0) && stall_en_i && stall_lfsr[0]);
    lat_eff_c = (latency_i == 4'd0) ? 4'd1 : latency_i;
    acc_due_c = cnt + 8'(lat_eff_c);
    cnt_nxt_c = cnt + 8'd1;

    mask_val_c = obi_req.addr[DATA_WIDTH-1:0] & VALUE_MASK[DATA_WIDTH-1:0];
    acc_data_c = '0;
    if (!obi_req.we) begin
      case (mode_i)
        MODE_ADDR_MASK: acc_data_c = 32'({mask_val_c, mask_val_c});
        MODE_LFSR:      acc_data_c = data_lfsr;
        MODE_ZERO:      acc_data_c = '0;
        default:        acc_data_c = obi_req.addr;
      endcase
`ifdef PIXEL_OBI_MEM_WRITE_EN
      if (store_vld[st_idx_c]) acc_data_c = store_mem[st_idx_c];
`endif
    end

    // Head is due when next-cycle count has reached its due stamp (mod-256 window).
    head_age_c   = cnt_nxt_c - fifo_due[rd_ptr];
    head_ready_c = (fifo_cnt != '0) && !head_age_c[7];
    // Latency-1 accept into an empty FIFO goes straight to the response register.
    bypass_c     = (fifo_cnt == '0) && gnt_c && (lat_eff_c == 4'd1);
    pop_c        = head_ready_c;
    push_c       = gnt_c && !bypass_c;
  end

  // LFSRs, cycle counter, FIFO control and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_lfsr <= GNT_SEED;
      data_lfsr  <= VAL_SEED;
      cnt        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_cnt   <= '0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      stall_lfsr <= {stall_lfsr[0] ^ stall_lfsr[2] ^ stall_lfsr[3] ^ stall_lfsr[5],
                     stall_lfsr[15:1]};
      if (gnt_c && !obi_req.we && (mode_i == MODE_LFSR)) begin
        data_lfsr <= {data_lfsr[0] ^ data_lfsr[10] ^ data_lfsr[30] ^ data_lfsr[31],
                      data_lfsr[31:1]};
      end
      cnt <= cnt_nxt_c;
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push_c && !pop_c)      fifo_cnt <= fifo_cnt + CNT_W'(1);
      else if (pop_c && !push_c) fifo_cnt <= fifo_cnt - CNT_W'(1);
      rvalid_q <= pop_c || bypass_c;
      if (pop_c)         rdata_q <= fifo_data[rd_ptr];
      else if (bypass_c) rdata_q <= acc_data_c;
    end
  end

  // Response payload storage (no reset needed; guarded by fifo_cnt).
  always_ff @(posedge clk) begin
    if (push_c) begin
      fifo_data[wr_ptr] <= acc_data_c;
      fifo_due[wr_ptr]  <= acc_due_c;
    end
  end

  always_comb begin
    obi_rsp        = '0;
    obi_rsp.gnt    = gnt_c;
    obi_rsp.rvalid = rvalid_q;
    obi_rsp.rdata  = rdata_q;
  end

endmodule

// File: tb/tb_pixel_obi_mem_mo.sv
// Self-checking bench for pixel_obi_mem_mo: a cycle-level reference model
// (queue of pending responses with their due cycles, LFSRs from their
// polynomials) is stepped alongside the DUT.
module tb_pixel_obi_mem_mo;
  import hsid_x_obi_inf_pkg::*;

  localparam int unsigned MAX_OUT    = 4;
  localparam int unsigned RANDOM_GNT = 1;
  localparam logic [15:0] GNT_SEED   = 16'hACE1;
  localparam logic [31:0] VAL_SEED   = 32'h1234_5678;
  localparam logic [31:0] VALUE_MASK = 32'h0000_3FFF;

  logic       clk = 1'b0;
  logic       rst_n;
  obi_req_t   req_s;
  obi_resp_t  rsp_s;
  logic [1:0] mode;
  logic [3:0] lat;
  logic       stall_en;

  always #5 clk = ~clk;

  pixel_obi_mem_mo #(
    .DATA_WIDTH(16), .MAX_OUTSTANDING(MAX_OUT), .RANDOM_GNT(RANDOM_GNT),
    .GNT_SEED(GNT_SEED), .VAL_SEED(VAL_SEED), .VALUE_MASK(VALUE_MASK), .STORE_AW(6)
  ) dut (
    .clk(clk), .rst_n(rst_n), .obi_req(req_s), .obi_rsp(rsp_s),
    .mode_i(mode), .latency_i(lat), .stall_en_i(stall_en)
  );

  typedef struct {
    int          rc;
    logic [31:0] data;
  } exp_t;

  exp_t        q[$];
  int          checks, errors;
  int          cyc, last_rc, grants, stall_cycles;
  logic [15:0] stall_m;
  logic [31:0] data_m, last_data;
  bit          resp_now;
`ifdef PIXEL_OBI_MEM_WRITE_EN
  logic [31:0] st_m [int];
`endif

  function automatic logic [15:0] stall_next(input logic [15:0] s);
    return {^(s & 16'h002D), s[15:1]};
  endfunction

  function automatic logic [31:0] data_next(input logic [31:0] s);
    return {^(s & 32'hC000_0401), s[31:1]};
  endfunction

  function automatic logic [31:0] model_data(input logic w, input logic [31:0] a,
                                             input logic [1:0] m);
    logic [31:0] vm;
    logic [15:0] v;
    vm = VALUE_MASK;
    if (w) return 32'h0;
`ifdef PIXEL_OBI_MEM_WRITE_EN
    if (st_m.exists(int'(a[7:2]))) return st_m[int'(a[7:2])];
`endif
    v = a[15:0] & vm[15:0];
    case (m)
      2'd0:    return {v, v};
      2'd1:    return data_m;
      2'd2:    return 32'h0;
      default: return a;
    endcase
  endfunction

  // One clock cycle: check gnt, update the model, then check rvalid/rdata.
  task automatic step();
    int          occ, l, rc;
    logic        eg;
    logic [31:0] ed;
    #1;
    occ = q.size() + (resp_now ? 1 : 0);
    eg  = req_s.req && (occ < int'(MAX_OUT)) && !((RANDOM_GNT != 0) && stall_en && stall_m[0]);
    checks++;
    if (rsp_s.gnt !== eg) begin
      errors++;
      $display("FAIL gnt cycle %0d got %b exp %b", cyc, rsp_s.gnt, eg);
    end
    if (req_s.req && !rsp_s.gnt) stall_cycles++;
    if (eg) begin
      ed = model_data(req_s.we, req_s.addr, mode);
`ifdef PIXEL_OBI_MEM_WRITE_EN
      if (req_s.we) begin
        logic [31:0] w;
        w = st_m.exists(int'(req_s.addr[7:2])) ? st_m[int'(req_s.addr[7:2])] : 32'h0;
        for (int b = 0; b < 4; b++)
          if (req_s.be[b]) w[8*b +: 8] = req_s.wdata[8*b +: 8];
        st_m[int'(req_s.addr[7:2])] = w;
      end
`endif
      if (!req_s.we && mode == 2'd1) data_m = data_next(data_m);
      l  = (lat == 4'd0) ? 1 : int'(lat);
      rc = cyc + l;
      if (rc <= last_rc) rc = last_rc + 1;
      last_rc = rc;
      q.push_back('{rc, ed});
      grants++;
    end
    @(posedge clk);
    cyc++;
    stall_m = stall_next(stall_m);
    #1;
    resp_now = (q.size() > 0) && (q[0].rc == cyc);
    checks++;
    if (rsp_s.rvalid !== resp_now) begin
      errors++;
      $display("FAIL rvalid cycle %0d got %b exp %b", cyc, rsp_s.rvalid, resp_now);
    end
    if (resp_now) begin
      last_data = q[0].data;
      void'(q.pop_front());
    end
    checks++;
    if (rsp_s.rdata !== last_data) begin
      errors++;
      $display("FAIL rdata cycle %0d got %h exp %h", cyc, rsp_s.rdata, last_data);
    end
    @(negedge clk);
  endtask

  task automatic do_reset(input int hold);
    req_s = '0;
    rst_n = 1'b0;
    repeat (hold) @(negedge clk);
    rst_n    = 1'b1;
    q.delete();
    cyc      = 0;
    last_rc  = -1;
    stall_m  = GNT_SEED;
    data_m   = VAL_SEED;
    last_data = 32'h0;
    resp_now = 1'b0;
`ifdef PIXEL_OBI_MEM_WRITE_EN
    st_m.delete();
`endif
  endtask

  // Hold req until the model grants it (bounded).
  task automatic issue(input logic w, input logic [31:0] a, input logic [3:0] b,
                       input logic [31:0] wd, output int gcyc);
    int g0, n;
    req_s.req = 1'b1; req_s.we = w; req_s.be = b; req_s.addr = a; req_s.wdata = wd;
    gcyc = -1;
    n = 0;
    while (gcyc < 0 && n < 200) begin
      g0 = grants;
      step();
      if (grants != g0) gcyc = cyc - 1;
      n++;
    end
    req_s = '0;
    if (gcyc < 0) begin
      checks++; errors++;
      $display("FAIL issue_timeout addr %h got no grant exp grant", a);
    end
  endtask

  // Issue one request into an idle model and wait for its rvalid beat.
  task automatic single(input logic w, input logic [31:0] a, input logic [3:0] b,
                        input logic [31:0] wd, output logic [31:0] got, output int gcyc);
    int n;
    issue(w, a, b, wd, gcyc);
    n = 0;
    while (!resp_now && n < 30) begin step(); n++; end
    got = rsp_s.rdata;
    checks++;
    if (rsp_s.rvalid !== 1'b1) begin
      errors++;
      $display("FAIL single_rvalid addr %h got %b exp 1", a, rsp_s.rvalid);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() > 0 || resp_now) && n < 200) begin step(); n++; end
  endtask

  task automatic test_reset();
    mode = 2'd0; lat = 4'd1; stall_en = 1'b0;
    req_s = '0; rst_n = 1'b0;
    #3;
    checks++;
    if (rsp_s.gnt !== 1'b0 || rsp_s.rvalid !== 1'b0 || rsp_s.rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs got gnt %b rvalid %b rdata %h exp 0 0 0",
               rsp_s.gnt, rsp_s.rvalid, rsp_s.rdata);
    end
    @(negedge clk);
    do_reset(2);
    repeat (4) step();
  endtask

  task automatic test_addr_mask();
    logic [31:0] got;
    int          g;
    mode = 2'd0; lat = 4'd1; stall_en = 1'b0;
    single(1'b0, 32'h0000_0004, 4'hF, 32'h0, got, g);
    checks++;
    if (got !== 32'h0004_0004 || cyc != g + 1) begin
      errors++;
      $display("FAIL t1_read4 got %h at +%0d exp 00040004 at +1", got, cyc - g);
    end
    single(1'b0, 32'h0000_7FFC, 4'hF, 32'h0, got, g);
    checks++;
    if (got !== 32'h3FFC_3FFC) begin
      errors++;
      $display("FAIL t2_read7ffc got %h exp 3ffc3ffc", got);
    end
    single(1'b0, 32'h0001_4004, 4'hF, 32'h0, got, g);
    for (int i = 0; i < 8; i++) begin
      mode = 2'(i % 4);
      issue(1'b0, $urandom, 4'hF, 32'h0, g);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int g[6];
    int n, k, g0;
    mode = 2'd3; lat = 4'd5; stall_en = 1'b0;
    req_s = '0; req_s.req = 1'b1; req_s.be = 4'hF; req_s.addr = $urandom;
    k = 0; n = 0;
    while (k < 6 && n < 60) begin
      g0 = grants;
      step();
      if (grants != g0) begin
        g[k] = cyc - 1;
        k++;
        req_s.addr = $urandom;
      end
      n++;
    end
    req_s = '0;
    checks++;
    if (k != 6) begin
      errors++;
      $display("FAIL t3_grants got %0d exp 6", k);
    end else begin
      checks++;
      if (g[3] - g[0] != 3 || g[4] - g[0] != 6 || g[5] - g[0] != 7) begin
        errors++;
        $display("FAIL t3_grant_cycles got +%0d +%0d +%0d exp +3 +6 +7",
                 g[3] - g[0], g[4] - g[0], g[5] - g[0]);
      end
    end
    drain();
  endtask

  task automatic test_random_stall();
    int n, g0;
    stall_en = 1'b1; lat = 4'd1; mode = 2'd3;
    stall_cycles = 0;
    req_s = '0; req_s.req = 1'b1; req_s.be = 4'hF; req_s.addr = $urandom;
    g0 = grants; n = 0;
    while (grants - g0 < 64 && n < 2000) begin
      int gb;
      gb = grants;
      step();
      if (grants != gb) begin
        req_s.addr = $urandom;
        mode = 2'($urandom_range(3, 0));
        lat  = 4'($urandom_range(4, 0));
      end
      n++;
    end
    req_s = '0;
    checks++;
    if (grants - g0 < 64) begin
      errors++;
      $display("FAIL t4_grants got %0d exp 64", grants - g0);
    end
    checks++;
    if (stall_cycles == 0) begin
      errors++;
      $display("FAIL t4_stalls got %0d exp >0", stall_cycles);
    end
    stall_en = 1'b0;
    drain();
  endtask

  task automatic test_lfsr();
    logic [31:0] got;
    int          g;
    do_reset(2);
    mode = 2'd1; lat = 4'd1; stall_en = 1'b0;
    single(1'b0, $urandom, 4'hF, 32'h0, got, g);
    checks++;
    if (got !== 32'h1234_5678) begin
      errors++;
      $display("FAIL t5_lfsr_first got %h exp 12345678", got);
    end
    single(1'b0, $urandom, 4'hF, 32'h0, got, g);
    single(1'b0, $urandom, 4'hF, 32'h0, got, g);
    mode = 2'd2;
    single(1'b0, 32'hFFFF_FFFC, 4'hF, 32'h0, got, g);
    checks++;
    if (got !== 32'h0) begin
      errors++;
      $display("FAIL t5_zero got %h exp 0", got);
    end
    drain();
  endtask

  task automatic test_reset_pending();
    logic [31:0] got;
    int          g;
    mode = 2'd3; lat = 4'd10; stall_en = 1'b0;
    for (int i = 0; i < 3; i++) issue(1'b0, $urandom, 4'hF, 32'h0, g);
    do_reset(2);
    repeat (20) step();
    lat = 4'd2;
    single(1'b1, 32'h0000_0008, 4'b0011, 32'hDEAD_BEEF, got, g);
    checks++;
    if (got !== 32'h0) begin
      errors++;
      $display("FAIL t6_write_rdata got %h exp 0", got);
    end
    mode = 2'd0;
    single(1'b0, 32'h0000_0008, 4'hF, 32'h0, got, g);
    checks++;
`ifdef PIXEL_OBI_MEM_WRITE_EN
    if (got !== 32'h0000_BEEF) begin
      errors++;
      $display("FAIL t6_readback got %h exp 0000beef", got);
    end
`else
    if (got !== 32'h0008_0008) begin
      errors++;
      $display("FAIL t6_readback got %h exp 00080008", got);
    end
`endif
    drain();
  endtask

  initial begin
    checks = 0; errors = 0; grants = 0; stall_cycles = 0;
    cyc = 0; last_rc = -1; resp_now = 1'b0; last_data = 32'h0;
    stall_m = GNT_SEED; data_m = VAL_SEED;
    test_reset();
    test_addr_mask();
    test_back_to_back();
    test_random_stall();
    test_lfsr();
    test_reset_pending();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
